// File: rtl/rv_dec_pkg.sv
// Shared opcode, ALU-op and branch-type encodings plus the decoded control bundle.
// The immediate is kept out of the bundle so its width can follow each module's XLEN.
package rv_dec_pkg;

   localparam logic [4:0] OPC_RTYPE  = 5'b01100;
   localparam logic [4:0] OPC_ITYPE  = 5'b00100;
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_XORACC = 5'b11100;

   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SLL  = 4'd6;
   localparam logic [3:0] ALU_SRL  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_NZ   = 2'b01;
   localparam logic [1:0] BR_Z    = 2'b11;

   typedef struct packed {
      logic [3:0] aluop;
      logic       reg_w;
      logic       mem_w;
      logic       i_type;
      logic       mem_out_wb;
      logic       xor_acc_en;
      logic       illegal;
      logic [1:0] branch;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } dec_bundle_t;

   // R-type and I-type share the funct3 -> ALU op mapping.
   function automatic logic [3:0] alu_of_f3(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/rv_decode_core.sv
// Combinational RV32/64 subset decoder: instruction word -> control bundle + immediate.
// Optional XOR-accumulate opcode enabled by defining XORACC_EN.
module rv_decode_core
   import rv_dec_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   output dec_bundle_t     ctl,
   output logic [XLEN-1:0] imm
);

   // Upper bits that must be zero for SLLI/SRLI; RV64 uses a 6-bit shamt.
   localparam logic [6:0] SHAMT_HI = (XLEN == 64) ? 7'b1111110 : 7'b1111111;

   logic [2:0] f3;
   logic [6:0] f7;
   logic       legal;

   assign f3 = instr[14:12];
   assign f7 = instr[31:25];

   always_comb begin
      ctl   = '0;
      imm   = '0;
      legal = 1'b0;
      case (instr[6:2])
         OPC_RTYPE: begin
            legal     = (f7 == 7'h00) || (f3 == 3'b000 && f7 == 7'h20);
            ctl.aluop = f7[5] ? ALU_SUB : alu_of_f3(f3);
            ctl.reg_w = 1'b1;
         end
         OPC_ITYPE: begin
            legal      = !(f3 == 3'b001 || f3 == 3'b101) || ((f7 & SHAMT_HI) == 7'h00);
            ctl.aluop  = alu_of_f3(f3);
            ctl.reg_w  = 1'b1;
            ctl.i_type = 1'b1;
            imm        = {{(XLEN-12){instr[31]}}, instr[31:20]};
         end
         OPC_LOAD: begin
            legal          = 1'b1;
            ctl.aluop      = ALU_ADD;
            ctl.reg_w      = 1'b1;
            ctl.i_type     = 1'b1;
            ctl.mem_out_wb = 1'b1;
            imm            = {{(XLEN-12){instr[31]}}, instr[31:20]};
         end
         OPC_STORE: begin
            legal      = 1'b1;
            ctl.aluop  = ALU_ADD;
            ctl.mem_w  = 1'b1;
            ctl.i_type = 1'b1;
            imm        = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         end
         OPC_BRANCH: begin
            legal      = (f3[2:1] != 2'b01);
            ctl.aluop  = !f3[2] ? ALU_XOR : (f3[1] ? ALU_SLTU : ALU_SLT);
            // BEQ/BGE/BGEU take on a zero compare result, the others on non-zero.
            ctl.branch = (f3[0] == f3[2]) ? BR_Z : BR_NZ;
            imm        = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
         end
`ifdef XORACC_EN
         OPC_XORACC: begin
            legal          = 1'b1;
            ctl.xor_acc_en = 1'b1;
         end
`endif
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         ctl         = '0;
         imm         = '0;
         ctl.illegal = 1'b1;
      end
      ctl.rs1 = instr[19:15];
      ctl.rs2 = instr[24:20];
      ctl.rd  = instr[11:7];
   end

endmodule

// File: rtl/mt_decode_stage.sv
// Multi-thread decode stage: decoder, 2-entry output FIFO, per-thread branch blocking and flush.
// Build option XORACC_EN (see rv_decode_core) adds the XOR-accumulate opcode.
module mt_decode_stage
   import rv_dec_pkg::*;
#(
   parameter  int XLEN        = 64,
   parameter  int NUM_THREADS = 4,
   localparam int TID_W       = $clog2(NUM_THREADS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_instr,
   input  logic [TID_W-1:0]       in_tid,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [TID_W-1:0]       out_tid,
   output logic [3:0]             out_aluop,
   output logic                   out_reg_w,
   output logic                   out_mem_w,
   output logic                   out_i_type,
   output logic                   out_mem_out_wb,
   output logic                   out_xor_acc_en,
   output logic                   out_illegal,
   output logic [1:0]             out_branch,
   output logic [XLEN-1:0]        out_imm,
   output logic [4:0]             out_rs1,
   output logic [4:0]             out_rs2,
   output logic [4:0]             out_rd,
   input  logic                   br_resolve_valid,
   input  logic [TID_W-1:0]       br_resolve_tid,
   input  logic                   flush_valid,
   input  logic [TID_W-1:0]       flush_tid,
   output logic [NUM_THREADS-1:0] thread_blocked
);

   typedef struct packed {
      logic [TID_W-1:0] tid;
      dec_bundle_t      ctl;
      logic [XLEN-1:0]  imm;
   } entry_t;

   entry_t                 mem [2];
   logic [1:0]             killed;
   logic                   head;
   logic [1:0]             count;
   logic                   tail;
   dec_bundle_t            dec_ctl;
   logic [XLEN-1:0]        dec_imm;
   logic                   accept;
   logic                   push;
   logic                   pop;
   logic                   head_killed;
   logic [NUM_THREADS-1:0] blocked_nxt;
   entry_t                 head_e;

   rv_decode_core #(.XLEN(XLEN)) u_core (
      .instr (in_instr),
      .ctl   (dec_ctl),
      .imm   (dec_imm)
   );

   assign tail        = head ^ count[0];
   assign in_ready    = (count != 2'd2) && !thread_blocked[in_tid];
   assign accept      = in_valid && in_ready;
   // A same-cycle flush of the issuing thread swallows the instruction.
   assign push        = accept && !(flush_valid && flush_tid == in_tid);
   assign head_killed = killed[head];
   assign out_valid   = (count != 2'd0) && !head_killed;
   assign pop         = (count != 2'd0) && (head_killed || out_ready);

   always_comb begin
      blocked_nxt = thread_blocked;
      if (br_resolve_valid)
         blocked_nxt[br_resolve_tid] = 1'b0;
      if (push && dec_ctl.branch != BR_NONE)
         blocked_nxt[in_tid] = 1'b1;
      if (flush_valid)
         blocked_nxt[flush_tid] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0]         <= '0;
         mem[1]         <= '0;
         killed         <= '0;
         head           <= 1'b0;
         count          <= 2'd0;
         thread_blocked <= '0;
      end else begin
         // Stale slots may get marked too; a push into them clears the mark.
         for (int i = 0; i < 2; i++)
            if (flush_valid && mem[i].tid == flush_tid)
               killed[i] <= 1'b1;
         if (push) begin
            mem[tail]    <= '{tid: in_tid, ctl: dec_ctl, imm: dec_imm};
            killed[tail] <= 1'b0;
         end
         head           <= head ^ pop;
         count          <= count + {1'b0, push} - {1'b0, pop};
         thread_blocked <= blocked_nxt;
      end
   end

   assign head_e         = mem[head];
   assign out_tid        = head_e.tid;
   assign out_aluop      = head_e.ctl.aluop;
   assign out_reg_w      = head_e.ctl.reg_w;
   assign out_mem_w      = head_e.ctl.mem_w;
   assign out_i_type     = head_e.ctl.i_type;
   assign out_mem_out_wb = head_e.ctl.mem_out_wb;
   assign out_xor_acc_en = head_e.ctl.xor_acc_en;
   assign out_illegal    = head_e.ctl.illegal;
   assign out_branch     = head_e.ctl.branch;
   assign out_imm        = head_e.imm;
   assign out_rs1        = head_e.ctl.rs1;
   assign out_rs2        = head_e.ctl.rs2;
   assign out_rd         = head_e.ctl.rd;

endmodule

// File: tb/tb_mt_decode_stage.sv
// Bench for mt_decode_stage: directed scenarios then random traffic against a queue-based model.
module tb_mt_decode_stage;

   localparam int XLEN = 64;
   localparam int NT   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready;
   logic [31:0]   in_instr;
   logic [1:0]    in_tid;
   logic          out_valid, out_ready;
   logic [1:0]    out_tid;
   logic [3:0]    out_aluop;
   logic          out_reg_w, out_mem_w, out_i_type, out_mem_out_wb, out_xor_acc_en, out_illegal;
   logic [1:0]    out_branch;
   logic [XLEN-1:0] out_imm;
   logic [4:0]    out_rs1, out_rs2, out_rd;
   logic          br_resolve_valid, flush_valid;
   logic [1:0]    br_resolve_tid, flush_tid;
   logic [NT-1:0] thread_blocked;

   always #5 clk = ~clk;

   mt_decode_stage #(.XLEN(XLEN), .NUM_THREADS(NT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tid(in_tid),
      .out_valid(out_valid), .out_ready(out_ready), .out_tid(out_tid),
      .out_aluop(out_aluop), .out_reg_w(out_reg_w), .out_mem_w(out_mem_w),
      .out_i_type(out_i_type), .out_mem_out_wb(out_mem_out_wb),
      .out_xor_acc_en(out_xor_acc_en), .out_illegal(out_illegal),
      .out_branch(out_branch), .out_imm(out_imm),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .br_resolve_valid(br_resolve_valid), .br_resolve_tid(br_resolve_tid),
      .flush_valid(flush_valid), .flush_tid(flush_tid),
      .thread_blocked(thread_blocked)
   );

   typedef struct {
      int          tid;
      bit          killed;
      logic [3:0]  aluop;
      logic        reg_w, mem_w, i_type, wb, xacc, ill;
      logic [1:0]  br;
      logic [63:0] imm;
      logic [4:0]  rs1, rs2, rd;
   } exp_t;

   exp_t    mq[$];
   logic [NT-1:0] mblk = '0;
   int      errors = 0;
   int      checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] sx(input logic [31:0] v, input int bits);
      longint t;
      t = longint'(v);
      t = t <<< (64 - bits);
      return t >>> (64 - bits);
   endfunction

   // Reference decode written straight from the instruction table.
   function automatic exp_t ref_dec(input logic [31:0] ins);
      exp_t e;
      logic [3:0] tbl [8];
      logic [2:0] f3;
      logic [6:0] f7;
      bit ok;
      tbl = '{4'd1, 4'd6, 4'd8, 4'd9, 4'd5, 4'd7, 4'd4, 4'd3};
      f3 = ins[14:12];
      f7 = ins[31:25];
      e  = '{default: 0};
      ok = 0;
      case (ins[6:2])
         5'b01100: begin
            ok = (f7 == 0) || (f3 == 0 && f7 == 7'h20);
            e.aluop = (f7 == 7'h20) ? 4'd2 : tbl[f3];
            e.reg_w = 1;
         end
         5'b00100: begin
            ok = !(f3 == 1 || f3 == 5) || (ins[31:26] == 0);
            e.aluop = tbl[f3]; e.reg_w = 1; e.i_type = 1;
            e.imm = sx({20'b0, ins[31:20]}, 12);
         end
         5'b00000: begin
            ok = 1; e.aluop = 1; e.reg_w = 1; e.i_type = 1; e.wb = 1;
            e.imm = sx({20'b0, ins[31:20]}, 12);
         end
         5'b01000: begin
            ok = 1; e.aluop = 1; e.mem_w = 1; e.i_type = 1;
            e.imm = sx({20'b0, ins[31:25], ins[11:7]}, 12);
         end
         5'b11000: begin
            ok = (f3 != 2 && f3 != 3);
            e.aluop = (f3 < 2) ? 4'd5 : ((f3 < 6) ? 4'd8 : 4'd9);
            e.br = (f3 == 0 || f3 == 5 || f3 == 7) ? 2'b11 : 2'b01;
            e.imm = sx({19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
         end
`ifdef XORACC_EN
         5'b11100: begin ok = 1; e.xacc = 1; end
`endif
         default: ok = 0;
      endcase
      if (!ok) begin
         e = '{default: 0};
         e.ill = 1;
      end
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.rd  = ins[11:7];
      return e;
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [31:0] r;
      int k;
      r = $urandom();
      k = $urandom_range(0, 7);
      case (k)
         0: begin
            r[6:0] = 7'b0110011;
            if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
         end
         1: begin
            r[6:0] = 7'b0010011;
            if ($urandom_range(0, 1) != 0) r[31:26] = 6'h0;
         end
         2: r[6:0] = 7'b0000011;
         3: r[6:0] = 7'b0100011;
         4, 5: r[6:0] = 7'b1100011;
         6: r[6:0] = 7'b1110011;
         default: ;
      endcase
      return r;
   endfunction

   // One clock: check DUT against model before the edge, then advance the model.
   task automatic cycle();
      bit   acc, pop;
      exp_t e;
      @(negedge clk);
      chk("in_ready", in_ready, (mq.size() < 2) && !mblk[in_tid]);
      chk("blocked", thread_blocked, mblk);
      if (mq.size() > 0 && !mq[0].killed) begin
         chk("out_valid", out_valid, 1);
         chk("tid", out_tid, mq[0].tid);
         chk("aluop", out_aluop, mq[0].aluop);
         chk("ctl", {out_reg_w, out_mem_w, out_i_type, out_mem_out_wb, out_xor_acc_en, out_illegal},
             {mq[0].reg_w, mq[0].mem_w, mq[0].i_type, mq[0].wb, mq[0].xacc, mq[0].ill});
         chk("branch", out_branch, mq[0].br);
         chk("imm", out_imm, mq[0].imm);
         chk("regs", {out_rs1, out_rs2, out_rd}, {mq[0].rs1, mq[0].rs2, mq[0].rd});
      end else begin
         chk("out_valid", out_valid, 0);
      end
      if (rst) begin
         mq.delete();
         mblk = '0;
      end else begin
         acc = in_valid && (mq.size() < 2) && !mblk[in_tid];
         pop = (mq.size() > 0) && (mq[0].killed || out_ready);
         if (pop) void'(mq.pop_front());
         if (flush_valid)
            foreach (mq[i]) if (mq[i].tid == int'(flush_tid)) mq[i].killed = 1;
         if (br_resolve_valid) mblk[br_resolve_tid] = 1'b0;
         if (acc && !(flush_valid && flush_tid == in_tid)) begin
            e = ref_dec(in_instr);
            e.tid = int'(in_tid);
            mq.push_back(e);
            if (e.br != 2'b00) mblk[in_tid] = 1'b1;
         end
         if (flush_valid) mblk[flush_tid] = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; in_instr = 32'h0; in_tid = 0; out_ready = 1;
      br_resolve_valid = 0; br_resolve_tid = 0; flush_valid = 0; flush_tid = 0;
   endtask

   task automatic issue(input logic [31:0] ins, input logic [1:0] tid);
      in_valid = 1; in_instr = ins; in_tid = tid;
      cycle();
      in_valid = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_blocked", thread_blocked, 0);
      chk("rst_fields", {out_tid, out_aluop, out_reg_w, out_mem_w, out_i_type, out_illegal,
                         out_branch, out_rs1, out_rs2, out_rd}, 0);
      chk("rst_imm", out_imm, 0);

      // ADDI x1,x0,-1
      issue(32'hFFF00093, 2'd0);
      chk("addi_valid", out_valid, 1);
      chk("addi_aluop", out_aluop, 1);
      chk("addi_rw_it", {out_reg_w, out_i_type, out_illegal}, 3'b110);
      chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi_rd", out_rd, 1);
      cycle();

      // BEQ x1,x2,+8 on thread 2 blocks it until resolved
      issue(32'h00208463, 2'd2);
      chk("beq_branch", out_branch, 2'b11);
      chk("beq_imm", out_imm, 64'd8);
      chk("beq_blocked", thread_blocked, 4'b0100);
      in_tid = 2; #1;
      chk("blk_ready_t2", in_ready, 0);
      in_tid = 1; #1;
      chk("blk_ready_t1", in_ready, 1);
      cycle();
      br_resolve_valid = 1; br_resolve_tid = 2;
      cycle();
      br_resolve_valid = 0;
      chk("resolved", thread_blocked, 0);

      // Backpressure: two accepted, third stalls, drained in order
      out_ready = 0;
      issue(32'h002081B3, 2'd0);
      issue(32'h00704293, 2'd1);
      in_valid = 1; in_instr = 32'h00106313; in_tid = 3; #1;
      chk("full_ready", in_ready, 0);
      cycle();
      in_valid = 0;
      out_ready = 1;
      chk("drain0", {out_tid, out_aluop}, {2'd0, 4'd1});
      cycle();
      chk("drain1", {out_tid, out_aluop, out_imm[7:0]}, {2'd1, 4'd5, 8'd7});
      cycle();
      chk("drained", out_valid, 0);

      // Flush thread 1 behind a held queue {tid1 ADD, tid3 SUB}
      out_ready = 0;
      issue(32'h002081B3, 2'd1);
      issue(32'h402081B3, 2'd3);
      flush_valid = 1; flush_tid = 1;
      cycle();
      flush_valid = 0; out_ready = 1;
      chk("flush_silent", out_valid, 0);
      cycle();
      chk("flush_sub", {out_valid, out_tid, out_aluop}, {1'b1, 2'd3, 4'd2});
      cycle();

      // Illegal encodings
      issue(32'h0000007F, 2'd0);
      chk("ill_op", {out_illegal, out_reg_w, out_aluop}, {1'b1, 1'b0, 4'd0});
      issue(32'hFE0081B3, 2'd0);
      chk("ill_f7", {out_illegal, out_reg_w, out_aluop}, {1'b1, 1'b0, 4'd0});
      issue(32'h00000073, 2'd1);
`ifdef XORACC_EN
      chk("xoracc", {out_xor_acc_en, out_illegal}, 2'b10);
`else
      chk("xoracc", {out_xor_acc_en, out_illegal}, 2'b01);
`endif
      cycle();

      // Reset while entries are queued
      out_ready = 0;
      issue(32'h00208463, 2'd0);
      issue(32'h002081B3, 2'd1);
      rst = 1;
      cycle();
      rst = 0;
      chk("midrst", {out_valid, in_ready, thread_blocked}, {1'b1 == 1'b0, 1'b1, 4'b0});

      for (int n = 0; n < 3000; n++) begin
         rst              = ($urandom_range(0, 499) == 0);
         in_valid         = ($urandom_range(0, 3) != 0);
         in_instr         = rnd_instr();
         in_tid           = 2'($urandom_range(0, 3));
         out_ready        = ($urandom_range(0, 3) != 0);
         br_resolve_valid = ($urandom_range(0, 3) == 0);
         br_resolve_tid   = 2'($urandom_range(0, 3));
         flush_valid      = ($urandom_range(0, 15) == 0);
         flush_tid        = 2'($urandom_range(0, 3));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
